// File: rtl/bird_sprite_render.sv
// bird_sprite_render: 3-stage sprite overlay with frame-latched position and ping-pong flap animation.
// Sprite ROMs are 1-cycle BRAMs sharing rom_addr; pix_hit/pix_rgb follow the pixel by 3 cycles.
module bird_sprite_render #(
    parameter int          SPR_W    = 30,
    parameter int          SPR_H    = 30,
    parameter logic [15:0] KEY      = 16'hF81F,
    parameter int          FLAP_DIV = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic        de,
    input  logic [10:0] pix_x,
    input  logic [10:0] pix_y,
    input  logic [10:0] bird_x,
    input  logic [10:0] bird_y,
    input  logic        flap_en,
    output logic [9:0]  rom_addr,
    input  logic [15:0] rom0_dout,
    input  logic [15:0] rom1_dout,
    input  logic [15:0] rom2_dout,
    output logic        pix_hit,
    output logic [15:0] pix_rgb,
    output logic [1:0]  phase
);
    typedef enum logic [1:0] {S0, S1, S2, S3} state_t;

    localparam logic [10:0] W11      = 11'(SPR_W);
    localparam logic [10:0] H11      = 11'(SPR_H);
    localparam logic [7:0]  DIV_LAST = 8'(FLAP_DIV - 1);

    state_t      state, state_nx;
    logic [7:0]  cnt, cnt_nx;
    logic [10:0] sx, sy, dx, dy;
    logic [9:0]  prod, addr;
    logic        in_box, in_box_d1, in_box_d2, de_d1, de_d2, hit;
    logic [1:0]  ph_d1, ph_d2;
    logic [15:0] data;

    // Offsets wrap, so pixels left of / above the sprite land far outside the box.
    assign dx     = pix_x - sx;
    assign dy     = pix_y - sy;
    assign in_box = (dx < W11) && (dy < H11);
    assign phase  = (state == S2) ? 2'd2 : (state == S0) ? 2'd0 : 2'd1;

    // dy*SPR_W as a constant shift-and-add over the set bits of SPR_W.
    always_comb begin
        prod = '0;
        for (int i = 0; i < 11; i++)
            if (W11[i]) prod = prod + (10'(dy) << i);
        addr = in_box ? prod + 10'(dx) : '0;
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (frame_start && flap_en) begin
            cnt_nx = (cnt == DIV_LAST) ? 8'd0 : cnt + 8'd1;
            if (cnt == DIV_LAST) state_nx = state_t'(state + 2'd1);
        end
    end

    assign data = (ph_d2 == 2'd2) ? rom2_dout : (ph_d2 == 2'd1) ? rom1_dout : rom0_dout;
    assign hit  = in_box_d2 & de_d2 & (data != KEY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S0;
            cnt       <= '0;
            sx        <= '0;
            sy        <= '0;
            rom_addr  <= '0;
            in_box_d1 <= 1'b0;
            de_d1     <= 1'b0;
            ph_d1     <= '0;
            in_box_d2 <= 1'b0;
            de_d2     <= 1'b0;
            ph_d2     <= '0;
            pix_hit   <= 1'b0;
            pix_rgb   <= '0;
        end else begin
            if (frame_start) begin
                sx <= bird_x;
                sy <= bird_y;
            end
            state     <= state_nx;
            cnt       <= cnt_nx;
            rom_addr  <= addr;
            in_box_d1 <= in_box;
            de_d1     <= de;
            ph_d1     <= phase;
            in_box_d2 <= in_box_d1;
            de_d2     <= de_d1;
            ph_d2     <= ph_d1;
            pix_hit   <= hit;
            pix_rgb   <= hit ? data : '0;
        end
    end
endmodule

// File: tb/tb_bird_sprite_render.sv
// tb_bird_sprite_render: scoreboard bench for the bird sprite renderer (SPR 30x30, FLAP_DIV=2).
module tb_bird_sprite_render;
    logic        clk = 1'b0;
    logic        rst_n, frame_start, de, flap_en, pix_hit;
    logic [10:0] pix_x, pix_y, bird_x, bird_y;
    logic [9:0]  rom_addr;
    logic [15:0] rom0_dout, rom1_dout, rom2_dout, pix_rgb;
    logic [1:0]  phase;

    logic [15:0] rom0 [1024];
    logic [15:0] rom1 [1024];
    logic [15:0] rom2 [1024];

    logic [10:0] sx_m, sy_m;
    logic [7:0]  cnt_m;
    logic [1:0]  st_m;
    logic [9:0]  exp_addr;
    logic [16:0] exp_q [$];
    int          n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rom0_dout <= rom0[rom_addr];
        rom1_dout <= rom1[rom_addr];
        rom2_dout <= rom2[rom_addr];
    end

    bird_sprite_render #(.FLAP_DIV(2)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .de(de),
        .pix_x(pix_x), .pix_y(pix_y), .bird_x(bird_x), .bird_y(bird_y),
        .flap_en(flap_en), .rom_addr(rom_addr), .rom0_dout(rom0_dout),
        .rom1_dout(rom1_dout), .rom2_dout(rom2_dout), .pix_hit(pix_hit),
        .pix_rgb(pix_rgb), .phase(phase)
    );

    function automatic logic [1:0] ph_of(input logic [1:0] s);
        return (s == 2'd2) ? 2'd2 : (s == 2'd0) ? 2'd0 : 2'd1;
    endfunction

    task automatic reset_model();
        sx_m = '0; sy_m = '0; cnt_m = '0; st_m = '0; exp_addr = '0;
        exp_q.delete();
        repeat (3) exp_q.push_back(17'd0);
    endtask

    // One pixel clock: check what the DUT shows now, then present a new pixel and predict it.
    task automatic step(input logic fs, input logic d, input logic [10:0] x, input logic [10:0] y);
        logic [16:0] e;
        logic [10:0] dxm, dym;
        logic        ib, h;
        logic [9:0]  a;
        logic [15:0] w;
        @(negedge clk);
        n_cmp++;
        if (rom_addr !== exp_addr) begin
            n_bad++; $display("FAIL rom_addr: got %0d want %0d", rom_addr, exp_addr);
        end
        n_cmp++;
        if (phase !== ph_of(st_m)) begin
            n_bad++; $display("FAIL phase: got %0d want %0d", phase, ph_of(st_m));
        end
        if (exp_q.size() >= 3) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (pix_hit !== e[16]) begin
                n_bad++; $display("FAIL pix_hit: got %b want %b", pix_hit, e[16]);
            end
            n_cmp++;
            if (pix_rgb !== e[15:0]) begin
                n_bad++; $display("FAIL pix_rgb: got %h want %h", pix_rgb, e[15:0]);
            end
        end
        frame_start = fs; de = d; pix_x = x; pix_y = y;
        dxm = x - sx_m;
        dym = y - sy_m;
        ib  = (dxm < 11'd30) && (dym < 11'd30);
        a   = ib ? 10'(int'(dym) * 30 + int'(dxm)) : 10'd0;
        w   = (ph_of(st_m) == 2'd0) ? rom0[a] : (ph_of(st_m) == 2'd1) ? rom1[a] : rom2[a];
        h   = ib && d && (w != 16'hF81F);
        exp_q.push_back({h, h ? w : 16'h0000});
        exp_addr = a;
        if (fs) begin
            sx_m = bird_x; sy_m = bird_y;
            if (flap_en) begin
                if (cnt_m == 8'd1) begin cnt_m = 0; st_m = st_m + 2'd1; end
                else cnt_m = cnt_m + 8'd1;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 11'd2000, 11'd2000);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; frame_start = 0; de = 0; flap_en = 0;
        pix_x = 11'd2000; pix_y = 11'd2000; bird_x = 0; bird_y = 0;
        #12;
        n_cmp++;
        if ({rom_addr, pix_hit, pix_rgb, phase} !== 29'd0) begin
            n_bad++; $display("FAIL reset_outputs: got %h want 0", {rom_addr, pix_hit, pix_rgb, phase});
        end
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();
        idle(3);
    endtask

    task automatic test_basic_hit();
        bird_x = 11'd100; bird_y = 11'd50;
        step(1'b1, 1'b0, 11'd2000, 11'd2000);
        step(1'b0, 1'b1, 11'd100, 11'd50);
        idle(3);
    endtask

    task automatic test_boundaries();
        step(1'b0, 1'b1, 11'd129, 11'd79);
        step(1'b0, 1'b1, 11'd130, 11'd50);
        step(1'b0, 1'b1, 11'd99, 11'd50);
        step(1'b0, 1'b1, 11'd100, 11'd49);
        step(1'b0, 1'b1, 11'd100, 11'd80);
        step(1'b0, 1'b0, 11'd110, 11'd60);
        for (int x = 95; x < 136; x++) step(1'b0, 1'b1, 11'(x), 11'd79);
        idle(3);
    endtask

    task automatic test_transparency();
        rom0[31] = 16'hF81F;
        step(1'b0, 1'b1, 11'd101, 11'd51);
        idle(3);
        rom0[31] = 16'h07E0;
        step(1'b0, 1'b1, 11'd101, 11'd51);
        idle(3);
    endtask

    task automatic test_tearing();
        bird_x = 11'd300;
        for (int x = 98; x < 103; x++) step(1'b0, 1'b1, 11'(x), 11'd50);
        for (int x = 298; x < 303; x++) step(1'b0, 1'b1, 11'(x), 11'd50);
        step(1'b1, 1'b0, 11'd2000, 11'd2000);
        for (int x = 98; x < 103; x++) step(1'b0, 1'b1, 11'(x), 11'd50);
        for (int x = 298; x < 303; x++) step(1'b0, 1'b1, 11'(x), 11'd50);
        idle(3);
    endtask

    task automatic test_animation();
        logic [1:0] seq [10];
        logic [1:0] held;
        seq = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0};
        flap_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            // Pulse coincides with an opaque pixel: it must use the pre-update phase.
            step(1'b1, 1'b1, 11'(300 + k), 11'd50);
            n_cmp++;
            if (phase !== seq[k]) begin
                n_bad++; $display("FAIL anim_seq[%0d]: got %0d want %0d", k, phase, seq[k]);
            end
            for (int x = 0; x < 3; x++) step(1'b0, 1'b1, 11'(305 + x), 11'(52 + k));
        end
        flap_en = 1'b0;
        step(1'b0, 1'b0, 11'd2000, 11'd2000);
        held = ph_of(st_m);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b1, 11'(310 + k), 11'd60);
            step(1'b0, 1'b1, 11'(311 + k), 11'd61);
            n_cmp++;
            if (phase !== held) begin
                n_bad++; $display("FAIL anim_hold[%0d]: got %0d want %0d", k, phase, held);
            end
        end
        idle(3);
    endtask

    task automatic test_reset_midline();
        for (int x = 0; x < 6; x++) step(1'b0, 1'b1, 11'(305 + x), 11'd55);
        n_cmp++;
        if (pix_hit !== 1'b1) begin
            n_bad++; $display("FAIL pre_reset_hit: got %b want 1", pix_hit);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({rom_addr, pix_hit, pix_rgb, phase} !== 29'd0) begin
            n_bad++; $display("FAIL async_reset: got %h want 0", {rom_addr, pix_hit, pix_rgb, phase});
        end
        repeat (2) @(negedge clk);
        frame_start = 0; de = 0; pix_x = 11'd2000; pix_y = 11'd2000;
        rst_n = 1'b1;
        reset_model();
        for (int x = 0; x < 8; x++) step(1'b0, 1'b1, 11'(5 + x), 11'd5);
        idle(3);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            rom0[i] = 16'h1000 + 16'(i * 3);
            rom1[i] = 16'h2000 + 16'(i);
            rom2[i] = 16'h4000 + 16'(i);
        end
        test_reset();
        test_basic_hit();
        test_boundaries();
        test_transparency();
        test_tearing();
        test_animation();
        test_reset_midline();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
